// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-memory controller: access sizes,
// FSM state encoding and datapath width.
package mem_ctrl_pkg;

   localparam int DATA_W = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RD_ISSUE  = 3'd1,
      ST_RD_DATA   = 3'd2,
      ST_RMW_ISSUE = 3'd3,
      ST_RMW_MERGE = 3'd4,
      ST_WR        = 3'd5
   } state_t;

endpackage

// File: rtl/mem_stage_ctrl_lane_align.sv
// Big-endian lane handling: extracts/extends a load lane from a memory word
// and merges a right-aligned store lane into a memory word.
module mem_lane_align
   import mem_ctrl_pkg::*;
(
   input  logic [1:0]        offset,
   input  logic [1:0]        size,
   input  logic              is_unsigned,
   input  logic [DATA_W-1:0] word,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] load_data,
   output logic [DATA_W-1:0] merged
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Byte offset 0 is the most significant lane.
   always_comb begin
      sel_byte = word[31:24];
      case (offset)
         2'd0: sel_byte = word[31:24];
         2'd1: sel_byte = word[23:16];
         2'd2: sel_byte = word[15:8];
         2'd3: sel_byte = word[7:0];
         default: sel_byte = word[31:24];
      endcase
      sel_half = offset[1] ? word[15:0] : word[31:16];
   end

   always_comb begin
      load_data = word;
      case (size)
         SZ_BYTE: load_data = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
         SZ_HALF: load_data = {{16{~is_unsigned & sel_half[15]}}, sel_half};
         default: load_data = word;
      endcase
   end

   always_comb begin
      merged = word;
      case (size)
         SZ_BYTE: begin
            case (offset)
               2'd0: merged = {wdata[7:0], word[23:0]};
               2'd1: merged = {word[31:24], wdata[7:0], word[15:0]};
               2'd2: merged = {word[31:16], wdata[7:0], word[7:0]};
               2'd3: merged = {word[31:8], wdata[7:0]};
               default: merged = word;
            endcase
         end
         SZ_HALF: merged = offset[1] ? {word[31:16], wdata[15:0]}
                                     : {wdata[15:0], word[15:0]};
         default: merged = wdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory controller driving a single-port BRAM with 1-cycle read
// latency. Optional MEMCTRL_PERF_EN adds saturating load/store/error counters.
//
// state        | meaning
// ST_IDLE      | ready for a request; errors answered directly from here
// ST_RD_ISSUE  | load word address presented to BRAM
// ST_RD_DATA   | douta valid; lane extracted into rsp_rdata
// ST_RMW_ISSUE | sub-word store: read of target word presented
// ST_RMW_MERGE | douta valid; store lane merged into dina
// ST_WR        | wea high, BRAM writes dina
module mem_stage_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 7
)(
   input  logic              clka,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              wea,
   output logic [ADDR_W-1:0] addra,
   output logic [31:0]       dina,
   input  logic [31:0]       douta
`ifdef MEMCTRL_PERF_EN
   ,
   output logic [15:0]       perf_loads,
   output logic [15:0]       perf_stores,
   output logic [15:0]       perf_errs
`endif
);

   state_t      state;
   logic [1:0]  cap_offset;
   logic [1:0]  cap_size;
   logic        cap_unsigned;
   logic [31:0] cap_wdata;
   logic        req_err;
   logic        accept;
   logic [31:0] load_data;
   logic [31:0] merged;

   assign accept = req_valid & req_ready;

   always_comb begin
      req_err = 1'b0;
      if (req_size == SZ_RSVD)                               req_err = 1'b1;
      if ((req_size == SZ_HALF) && req_addr[0])              req_err = 1'b1;
      if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
      if (|req_addr[31:ADDR_W+2])                            req_err = 1'b1;
   end

   mem_lane_align u_lane_align (
      .offset      (cap_offset),
      .size        (cap_size),
      .is_unsigned (cap_unsigned),
      .word        (douta),
      .wdata       (cap_wdata),
      .load_data   (load_data),
      .merged      (merged)
   );

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         req_ready    <= 1'b1;
         wea          <= 1'b0;
         addra        <= '0;
         dina         <= '0;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= '0;
         rsp_err      <= 1'b0;
         cap_offset   <= '0;
         cap_size     <= SZ_BYTE;
         cap_unsigned <= 1'b0;
         cap_wdata    <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         wea       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  cap_offset   <= req_addr[1:0];
                  cap_size     <= req_size;
                  cap_unsigned <= req_unsigned;
                  cap_wdata    <= req_wdata;
                  if (req_err) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end else begin
                     addra     <= req_addr[ADDR_W+1:2];
                     req_ready <= 1'b0;
                     if (!req_we) begin
                        state <= ST_RD_ISSUE;
                     end else if (req_size == SZ_WORD) begin
                        dina  <= req_wdata;
                        wea   <= 1'b1;
                        state <= ST_WR;
                     end else begin
                        state <= ST_RMW_ISSUE;
                     end
                  end
               end
            end
            ST_RD_ISSUE: state <= ST_RD_DATA;
            ST_RD_DATA: begin
               rsp_rdata <= load_data;
               rsp_valid <= 1'b1;
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            ST_RMW_ISSUE: state <= ST_RMW_MERGE;
            ST_RMW_MERGE: begin
               dina  <= merged;
               wea   <= 1'b1;
               state <= ST_WR;
            end
            ST_WR: begin
               rsp_valid <= 1'b1;
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            default: begin
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef MEMCTRL_PERF_EN
   // Counted on the edge that launches each response, so they track rsp_valid.
   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         perf_loads  <= '0;
         perf_stores <= '0;
         perf_errs   <= '0;
      end else begin
         if ((state == ST_RD_DATA) && (perf_loads != 16'hFFFF))
            perf_loads <= perf_loads + 16'd1;
         if ((state == ST_WR) && (perf_stores != 16'hFFFF))
            perf_stores <= perf_stores + 16'd1;
         if ((state == ST_IDLE) && accept && req_err && (perf_errs != 16'hFFFF))
            perf_errs <= perf_errs + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed-vector bench for mem_stage_ctrl with a behavioural 128x32 BRAM.
module tb_mem_stage_ctrl;

   logic        clka = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        wea;
   logic [6:0]  addra;
   logic [31:0] dina;
   logic [31:0] douta;

   logic [31:0] mem [0:127];
   int          wea_cnt = 0;
   logic [31:0] last_dina = '0;
   logic [6:0]  last_addra = '0;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clka = ~clka;

   mem_stage_ctrl #(.ADDR_W(7)) dut (
      .clka         (clka),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .wea          (wea),
      .addra        (addra),
      .dina         (dina),
      .douta        (douta)
   );

   // Read-first single-port BRAM, one-cycle read latency.
   always @(posedge clka) begin
      if (wea) begin
         mem[addra] <= dina;
         wea_cnt    = wea_cnt + 1;
         last_dina  = dina;
         last_addra = addra;
      end
      douta <= mem[addra];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // lat = clock edges after the accept edge until rsp_valid is seen.
   task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat);
      int n;
      @(negedge clka);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clka); n++; end
      @(posedge clka); #1;
      req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 20) begin @(posedge clka); #1; lat++; end
      rd = rsp_rdata;
      er = rsp_err;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          wc;

      for (int i = 0; i < 128; i++) mem[i] = 32'h0;
      mem[5] = 32'h11223344;
      mem[6] = 32'h8899AABB;
      mem[7] = 32'h55667788;

      #12;
      chk("rst_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_wea",   {31'b0, wea}, 32'd0);
      chk("rst_addra", {25'b0, addra}, 32'd0);
      chk("rst_dina",  dina, 32'd0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      @(negedge clka); rst_n = 1'b1;

      // Loads: rsp_valid after 2 edges past accept = 3rd cycle.
      do_req(1'b0, 2'b10, 1'b0, 32'h14, '0, rd, er, lat);
      chk("lw_rdata", rd, 32'h11223344);
      chk("lw_err", {31'b0, er}, 32'd0);
      chk("lw_latency", lat, 32'd2);
      do_req(1'b0, 2'b00, 1'b0, 32'h18, '0, rd, er, lat);
      chk("lb_rdata", rd, 32'hFFFFFF88);
      chk("lb_latency", lat, 32'd2);
      do_req(1'b0, 2'b00, 1'b1, 32'h19, '0, rd, er, lat);
      chk("lbu_rdata", rd, 32'h00000099);
      do_req(1'b0, 2'b01, 1'b0, 32'h1A, '0, rd, er, lat);
      chk("lh_rdata", rd, 32'hFFFFAABB);
      do_req(1'b0, 2'b01, 1'b1, 32'h18, '0, rd, er, lat);
      chk("lhu_rdata", rd, 32'h00008899);
      do_req(1'b0, 2'b00, 1'b0, 32'h1B, '0, rd, er, lat);
      chk("lb3_rdata", rd, 32'hFFFFFFBB);

      // SB read-modify-write
      wc = wea_cnt;
      do_req(1'b1, 2'b00, 1'b0, 32'h16, 32'h000000AB, rd, er, lat);
      chk("sb_latency", lat, 32'd3);
      chk("sb_rdata", rd, 32'd0);
      chk("sb_err", {31'b0, er}, 32'd0);
      chk("sb_wea_pulses", wea_cnt - wc, 32'd1);
      chk("sb_dina", last_dina, 32'h1122AB44);
      chk("sb_addra", {25'b0, last_addra}, 32'd5);
      do_req(1'b0, 2'b10, 1'b0, 32'h14, '0, rd, er, lat);
      chk("lw_after_sb", rd, 32'h1122AB44);

      // SH low half of word 6
      do_req(1'b1, 2'b01, 1'b0, 32'h1A, 32'hFFFF5A5A, rd, er, lat);
      do_req(1'b0, 2'b10, 1'b0, 32'h18, '0, rd, er, lat);
      chk("lw_after_sh", rd, 32'h88995A5A);

      // Error requests
      wc = wea_cnt;
      do_req(1'b0, 2'b10, 1'b0, 32'h02, '0, rd, er, lat);
      chk("lw_misalign_err", {31'b0, er}, 32'd1);
      chk("lw_misalign_rdata", rd, 32'd0);
      chk("err_latency", lat, 32'd0);
      do_req(1'b0, 2'b01, 1'b0, 32'h03, '0, rd, er, lat);
      chk("lh_misalign_err", {31'b0, er}, 32'd1);
      chk("lh_misalign_rdata", rd, 32'd0);
      do_req(1'b1, 2'b11, 1'b0, 32'h04, 32'h12345678, rd, er, lat);
      chk("rsvd_size_err", {31'b0, er}, 32'd1);
      chk("rsvd_size_rdata", rd, 32'd0);
      do_req(1'b1, 2'b10, 1'b0, 32'h200, 32'h12345678, rd, er, lat);
      chk("oor_err", {31'b0, er}, 32'd1);
      chk("oor_rdata", rd, 32'd0);
      chk("err_no_wea", wea_cnt - wc, 32'd0);
      chk("err_mem0_intact", mem[0], 32'd0);

      // Back-to-back SW then LW with req_valid held high
      @(negedge clka);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
      @(posedge clka); #1;
      req_we = 1'b0; req_wdata = '0;
      @(posedge clka); #1;
      chk("b2b_sw_rsp", {31'b0, rsp_valid}, 32'd1);
      chk("b2b_ready_in_rsp", {31'b0, req_ready}, 32'd1);
      @(posedge clka); #1;
      req_valid = 1'b0;
      chk("b2b_lw_accepted", {31'b0, req_ready}, 32'd0);
      lat = 0;
      while (!rsp_valid && lat < 20) begin @(posedge clka); #1; lat++; end
      chk("b2b_lw_latency", lat, 32'd2);
      chk("b2b_lw_rdata", rsp_rdata, 32'hDEADBEEF);

      // Reset during RMW_MERGE of SH to word 7
      wc = wea_cnt;
      @(negedge clka);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01;
      req_addr = 32'h1C; req_wdata = 32'h00001234;
      @(posedge clka); #1;
      req_valid = 1'b0;
      @(posedge clka); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_wea", {31'b0, wea}, 32'd0);
      @(posedge clka); #1;
      @(posedge clka); #1;
      chk("rst_hold_wea", {31'b0, wea}, 32'd0);
      @(negedge clka); rst_n = 1'b1;
      @(posedge clka); #1;
      chk("rst_release_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_no_write", wea_cnt - wc, 32'd0);
      chk("rst_word_intact", mem[7], 32'h55667788);
      do_req(1'b0, 2'b10, 1'b0, 32'h1C, '0, rd, er, lat);
      chk("rst_recover_lw", rd, 32'h55667788);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
